seg_display_arbiter: RTL and testbench

//  Shares the board's 4-digit seven-segment display among NUM_REQ requesters,
//  e.g. the volume meter, numeric readout and status messages.

---
 rtl/seg_disp_pkg.sv | 20 ++
 rtl/seg_scan_timer.sv | 42 ++++
 rtl/seg_display_arbiter.sv | 135 +++++++++++++
 tb/tb_seg_display_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg_disp_pkg;

    localparam int DIGIT_W = 8;
    localparam int FRAME_W = 32;

    localparam logic [6:0] BLANK_SEG = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Isolates the lowest set bit, i.e. the highest-priority active request.
    function automatic logic [31:0] prio_onehot(input logic [31:0] req);
        return req & (~req + 32'd1);
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit scan timer: a prescaler sets how long each digit is lit, a 2-bit
// digit counter walks the four anodes, and frame_tick marks the last cycle
// of digit 3.
module seg_scan_timer #(
    parameter int SCAN_DIV = 25000
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_clear,
    input  logic       i_enable,
    output logic [1:0] o_digit,
    output logic       o_frame_tick
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0] r_prescaler;
    logic [1:0]       r_digit;
    logic             w_pre_last;

    assign w_pre_last = (r_prescaler == PRE_LAST);

    // Prescaler and digit counter; the digit advances when the prescaler wraps.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_prescaler <= '0;
            r_digit     <= 2'd0;
        end else if (i_enable) begin
            if (w_pre_last) begin
                r_prescaler <= '0;
                r_digit     <= r_digit + 2'd1;
            end else begin
                r_prescaler <= r_prescaler + PRE_W'(1);
            end
        end
    end

    assign o_digit      = r_digit;
    assign o_frame_tick = i_enable && w_pre_last && (r_digit == 2'd3);

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares the 4-digit seven-segment display among NUM_REQ requesters.
// Fixed priority (index 0 highest) with a minimum hold in frames; the owner's
// frame is snapshotted at each frame boundary so the display never tears.
//
//  state | meaning
//  IDLE  | no owner, display blanked, scan timer held at zero
//  OWN   | one requester granted, its snapshot is scanned onto the anodes
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int NUM_REQ         = 3,
    parameter int SCAN_DIV        = 25000,
    parameter int MIN_HOLD_FRAMES = 8
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [NUM_REQ*32-1:0]  i_req_frame,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic                   o_frame_tick,
    output logic [6:0]             o_seg,
    output logic                   o_dp,
    output logic [3:0]             o_an
);

    localparam int HOLD_W = $clog2(MIN_HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD_FRAMES);

    state_t               r_state, w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
    logic [HOLD_W-1:0]    r_hold, w_hold_nxt, w_hold_inc;
    logic [FRAME_W-1:0]   r_snap, w_snap_sel;
    logic                 w_load;
    logic [NUM_REQ-1:0]   w_prio;
    logic [NUM_REQ-1:0]   w_higher;
    logic                 w_owner_req;
    logic [1:0]           w_digit;
    logic                 w_frame_tick;
    logic [DIGIT_W-1:0]   w_byte;

    seg_scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_timer (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_clear      (r_state == IDLE),
        .i_enable     (r_state == OWN),
        .o_digit      (w_digit),
        .o_frame_tick (w_frame_tick)
    );

    assign w_prio      = NUM_REQ'(prio_onehot(32'(i_req)));
    // Bits below the one-hot owner are the higher-priority requesters.
    assign w_higher    = i_req & (r_grant - NUM_REQ'(1));
    assign w_owner_req = |(i_req & r_grant);
    assign w_hold_inc  = (r_hold == HOLD_MAX) ? r_hold : r_hold + HOLD_W'(1);

    // Next-state and arbitration; decisions are only taken at frame boundaries.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_hold_nxt  = r_hold;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (|i_req) begin
                    w_state_nxt = OWN;
                    w_grant_nxt = w_prio;
                    w_hold_nxt  = '0;
                    w_load      = 1'b1;
                end
            end
            OWN: begin
                if (w_frame_tick) begin
                    w_load = 1'b1;
                    if (!w_owner_req) begin
                        w_hold_nxt = '0;
                        if (|i_req) begin
                            w_grant_nxt = w_prio;
                        end else begin
                            w_state_nxt = IDLE;
                            w_grant_nxt = '0;
                            w_load      = 1'b0;
                        end
                    end else if ((|w_higher) && (w_hold_inc >= HOLD_MAX)) begin
                        w_grant_nxt = w_prio;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = w_hold_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // Frame of whichever requester will own the display next.
    always_comb begin
        w_snap_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_nxt[i]) begin
                w_snap_sel = w_snap_sel | i_req_frame[FRAME_W*i +: FRAME_W];
            end
        end
    end

    // State, grant, hold counter and frame snapshot registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_hold  <= '0;
            r_snap  <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_hold  <= w_hold_nxt;
            if (w_load) begin
                r_snap <= w_snap_sel;
            end
        end
    end

    assign w_byte       = r_snap[DIGIT_W*w_digit +: DIGIT_W];
    assign o_grant      = r_grant;
    assign o_frame_tick = w_frame_tick;
    assign o_an         = (r_state == OWN) ? ~(4'b0001 << w_digit) : AN_OFF;
    assign o_seg        = (r_state == OWN) ? w_byte[6:0] : BLANK_SEG;
    assign o_dp         = (r_state == OWN) ? w_byte[7] : 1'b1;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter with SCAN_DIV=4, MIN_HOLD_FRAMES=2.
module tb_seg_display_arbiter;

    localparam int NREQ      = 3;
    localparam int SDIV      = 4;
    localparam int MHF       = 2;
    localparam int FRAME_CYC = 4 * SDIV;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*32-1:0] frames;
    logic [NREQ-1:0]   o_grant;
    logic              o_frame_tick;
    logic [6:0]        o_seg;
    logic              o_dp;
    logic [3:0]        o_an;

    int checks   = 0;
    int failures = 0;

    seg_display_arbiter #(
        .NUM_REQ         (NREQ),
        .SCAN_DIV        (SDIV),
        .MIN_HOLD_FRAMES (MHF)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_req        (req),
        .i_req_frame  (frames),
        .o_grant      (o_grant),
        .o_frame_tick (o_frame_tick),
        .o_seg        (o_seg),
        .o_dp         (o_dp),
        .o_an         (o_an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner index (-1 = nobody), position within the frame,
    // completed-frame count and a copy of the owner's four bytes.
    int         m_owner = -1;
    int         m_pos   = 0;
    int         m_hold  = 0;
    logic [7:0] m_snap [4];

    function automatic int lowest(input logic [NREQ-1:0] r);
        for (int i = 0; i < NREQ; i++) if (r[i]) return i;
        return -1;
    endfunction

    task automatic load_snap(input logic [NREQ*32-1:0] fr);
        for (int d = 0; d < 4; d++) m_snap[d] = fr[32*m_owner + 8*d +: 8];
    endtask

    task automatic model_step(input logic r, input logic [NREQ-1:0] rq,
                              input logic [NREQ*32-1:0] fr);
        int  h;
        bit  hi;
        if (r) begin
            m_owner = -1; m_pos = 0; m_hold = 0;
        end else if (m_owner < 0) begin
            if (rq != 0) begin
                m_owner = lowest(rq); load_snap(fr); m_hold = 0; m_pos = 0;
            end
        end else if (m_pos == FRAME_CYC - 1) begin
            m_pos = 0;
            h = (m_hold + 1 > MHF) ? MHF : m_hold + 1;
            hi = 0;
            for (int i = 0; i < m_owner; i++) if (rq[i]) hi = 1;
            if (!rq[m_owner]) begin
                m_hold = 0;
                if (rq != 0) begin m_owner = lowest(rq); load_snap(fr); end
                else m_owner = -1;
            end else if (hi && h >= MHF) begin
                m_owner = lowest(rq); load_snap(fr); m_hold = 0;
            end else begin
                load_snap(fr); m_hold = h;
            end
        end else begin
            m_pos++;
        end
    endtask

    function automatic logic [15:0] model_out();
        logic [2:0] g;
        logic       t;
        logic [3:0] a;
        logic [7:0] b;
        int         d;
        d = m_pos / SDIV;
        if (m_owner < 0) begin
            g = 3'b000; t = 1'b0; a = 4'b1111; b = 8'hFF;
        end else begin
            g = 3'(1 << m_owner);
            t = (m_pos == FRAME_CYC - 1);
            a = ~(4'(1 << d));
            b = m_snap[d];
        end
        return {g, t, a, b};
    endfunction

    function automatic logic [15:0] dut_out();
        return {o_grant, o_frame_tick, o_an, o_dp, o_seg};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: DUT and model both consume the current inputs, then compare.
    task automatic step();
        @(posedge clk);
        model_step(rst, req, frames);
        #1;
        check("model", 32'(dut_out()), 32'(model_out()));
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic expect_disp(input string name, input logic [2:0] g, input logic t,
                               input logic [3:0] a, input logic [6:0] s, input logic d);
        check(name, {16'h0, o_grant, o_frame_tick, o_an, o_dp, o_seg},
                    {16'h0, g, t, a, d, s});
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [31:0] frame0;
        int          wait_n;
        logic [2:0]  grant;
        logic        tick;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{1'b1, 3'b111, 32'h99B0A4F9, 1,  3'b000, 1'b0, 4'b1111, 7'h7F, 1'b1};
        tbl[1]  = '{1'b1, 3'b111, 32'h99B0A4F9, 1,  3'b000, 1'b0, 4'b1111, 7'h7F, 1'b1};
        tbl[2]  = '{1'b1, 3'b111, 32'h99B0A4F9, 1,  3'b000, 1'b0, 4'b1111, 7'h7F, 1'b1};
        tbl[3]  = '{1'b0, 3'b001, 32'h99B0A4F9, 1,  3'b001, 1'b0, 4'b1110, 7'h79, 1'b1};
        tbl[4]  = '{1'b0, 3'b001, 32'h99B0A4F9, 4,  3'b001, 1'b0, 4'b1101, 7'h24, 1'b1};
        tbl[5]  = '{1'b0, 3'b001, 32'h99B0A4F9, 4,  3'b001, 1'b0, 4'b1011, 7'h30, 1'b1};
        tbl[6]  = '{1'b0, 3'b001, 32'h99B0A4F9, 4,  3'b001, 1'b0, 4'b0111, 7'h19, 1'b1};
        tbl[7]  = '{1'b0, 3'b001, 32'h99B0A4F9, 3,  3'b001, 1'b1, 4'b0111, 7'h19, 1'b1};
        tbl[8]  = '{1'b0, 3'b001, 32'h99B0A4F9, 1,  3'b001, 1'b0, 4'b1110, 7'h79, 1'b1};
        tbl[9]  = '{1'b0, 3'b000, 32'h99B0A4F9, 15, 3'b001, 1'b1, 4'b0111, 7'h19, 1'b1};
        tbl[10] = '{1'b0, 3'b000, 32'h99B0A4F9, 1,  3'b000, 1'b0, 4'b1111, 7'h7F, 1'b1};

        rst = 1'b1; req = '0; frames = '0;

        // Reset and single-owner scan, table driven.
        for (int k = 0; k < 11; k++) begin
            rst = tbl[k].rst; req = tbl[k].req; frames[31:0] = tbl[k].frame0;
            steps(tbl[k].wait_n);
            expect_disp($sformatf("tbl[%0d]", k), tbl[k].grant, tbl[k].tick,
                        tbl[k].an, tbl[k].seg, tbl[k].dp);
        end

        // Hold blocks preemption until the second boundary.
        frames = {32'h92B0A4F9, 32'h82F8C0A4, 32'h99B0A4C0};
        do_reset();
        req = 3'b100; step();
        expect_disp("t3_grant", 3'b100, 1'b0, 4'b1110, frames[70:64], frames[71]);
        steps(4); req = 3'b101;
        steps(11);
        check("t3_tick1", {29'h0, o_grant}, {29'h0, 3'b100});
        check("t3_tick1_pulse", {31'h0, o_frame_tick}, 32'h1);
        steps(16);
        check("t3_tick2", {28'h0, o_grant, o_frame_tick}, {28'h0, 3'b100, 1'b1});
        step();
        expect_disp("t3_preempt", 3'b001, 1'b0, 4'b1110, frames[6:0], frames[7]);

        // Owner drop mid-frame finishes on the snapshot, then releases.
        frames[31:0] = 32'h99B0A4F9;
        do_reset();
        req = 3'b001; step(); steps(4);
        req = 3'b000;
        expect_disp("t4_d1", 3'b001, 1'b0, 4'b1101, 7'h24, 1'b1);
        steps(4);
        expect_disp("t4_d2", 3'b001, 1'b0, 4'b1011, 7'h30, 1'b1);
        steps(4);
        expect_disp("t4_d3", 3'b001, 1'b0, 4'b0111, 7'h19, 1'b1);
        steps(3);
        check("t4_tick", {31'h0, o_frame_tick}, 32'h1);
        step();
        expect_disp("t4_idle", 3'b000, 1'b0, 4'b1111, 7'h7F, 1'b1);

        // No tearing: a frame change mid-scan waits for the boundary.
        do_reset();
        req = 3'b001; step(); steps(4);
        frames[31:0] = 32'hC0C0C0C0;
        steps(4);
        expect_disp("t5_old_d2", 3'b001, 1'b0, 4'b1011, 7'h30, 1'b1);
        steps(4);
        expect_disp("t5_old_d3", 3'b001, 1'b0, 4'b0111, 7'h19, 1'b1);
        steps(4);
        for (int d = 0; d < 4; d++) begin
            expect_disp($sformatf("t5_new_d%0d", d), 3'b001, 1'b0,
                        ~(4'(1 << d)), 7'h40, 1'b1);
            if (d < 3) steps(4);
        end

        // Reset mid-frame with request held, then re-grant from digit 0.
        frames[31:0] = 32'h99B0A4F9;
        do_reset();
        req = 3'b001; step(); steps(8);
        expect_disp("t6_d2", 3'b001, 1'b0, 4'b1011, 7'h30, 1'b1);
        rst = 1'b1; step();
        expect_disp("t6_reset", 3'b000, 1'b0, 4'b1111, 7'h7F, 1'b1);
        rst = 1'b0; step();
        expect_disp("t6_regrant", 3'b001, 1'b0, 4'b1110, 7'h79, 1'b1);

        // Randomised traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(0, 23) == 0) req[b] = ~req[b];
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(0, 7) == 0) frames[32*b +: 32] = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
